regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Two-port arbiter and sequencer for the 8 x 16-bit single-port register file. Accepts independent read/write requests from requesters A and B, arbitrates round-robin, drives the register file's single address/data/strobe port one operation at a time, and returns read data with a one-cycle valid pulse to the winning requester. Sits between the two datapath masters and the register file; it is the only driver of the register file's write and read strobes.

## Interface
- No parameters. Data width is fixed at 16 bits and address width at 3 bits.
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- a_req / b_req  in  1  request; sampled only in IDLE.
- a_we / b_we  in  1  1 = write, 0 = read; must be stable while req is high and gnt has not yet been seen.
- a_addr / b_addr  in  3  register address.
- a_wdata / b_wdata  in  16  write data.
- a_gnt / b_gnt  out  1  one-cycle pulse: command accepted and latched.
- a_rvalid / b_rvalid  out  1  one-cycle pulse: a_rdata / b_rdata valid.
- a_rdata / b_rdata  out  16  read data; holds last value until the next read completes for that requester.
- busy  out  1  high in every state except IDLE.
- rf_wr_en  out  1  register file write strobe.
- rf_rd_en  out  1  register file read strobe.
- rf_addr  out  3  register file address.
- rf_wr_data  out  16  register file write data.
- rf_rd_data  in  16  register file read data; registered inside the register file, so it is valid one cycle after rf_rd_en.

## Operation
- FSM states: IDLE, ISSUE, CAPT.
- IDLE: with no request, stay. With one request, grant it. With both, grant the requester other than last_winner. On grant, latch we/addr/wdata, update last_winner, pulse x_gnt, load rf_* outputs, and go to ISSUE.
- ISSUE: drive exactly one of rf_wr_en / rf_rd_en for one cycle. On a write, go to IDLE. On a read, go to CAPT.
- CAPT: capture rf_rd_data into the owner's rdata register, pulse the owner's rvalid, and go to IDLE.
- rf_wr_en and rf_rd_en are never high together. Both are low outside ISSUE. rf_addr and rf_wr_data hold their last values when idle.
- Requests arriving outside IDLE are ignored until the next IDLE cycle. A requester holding req high after gnt issues a new transaction using its current command inputs.
- All outputs are registered.

## Timing
- Reset values: state = IDLE, last_winner = B (so A wins the first tie), and every output is 0 (gnt, rvalid, rdata, busy, rf_*).
- Write: req sampled in IDLE at cycle N. gnt and rf_wr_en are high in N+1. The register file commits at the end of N+1. IDLE is reached in N+2, so one write can complete every 2 cycles.
- Read: req sampled at N. gnt and rf_rd_en are high in N+1. rf_rd_data is valid in N+2. rvalid and rdata are visible in N+3, which is also an IDLE cycle. One read completes every 3 cycles.
- Back-to-back ties with both requests held alternate grants A, B, A, B, ...
- The non-winning requester waits at most one transaction.
- An asynchronous RST mid-operation immediately clears the strobes, gnt and rvalid. An in-flight read returns no rvalid. An in-flight write in ISSUE is not guaranteed to commit.

## Configuration
- REGARB_FIXED_PRIO_EN defined: ties are always granted to A, and last_winner is unused. B can starve while a_req is held high.
- REGARB_FIXED_PRIO_EN undefined (default): round-robin on ties as described above.

## Test plan
- Reset: assert RST with a_req = 1 -> all outputs 0, with no gnt while RST is high. Release RST -> a_gnt in the cycle after the first IDLE sample.
- A writes 0xBEEF to address 5, then A reads address 5 -> rf_wr_en one cycle with rf_addr = 5. The read then gives a_rvalid with a_rdata = 0xBEEF exactly 3 cycles after its req sample, and b_rvalid stays 0.
- A and B both hold req (A writes 0x1111 to address 1, B writes 0x2222 to address 2) -> grants in order A, B, A, B. Without the macro, no requester is granted twice in a row. With REGARB_FIXED_PRIO_EN, grants are A only.
- B reads address 7 while A requests during CAPT -> A is ignored until IDLE. b_rdata equals the contents of address 7, then a_gnt follows.
- RST pulse during CAPT of a read -> no rvalid, state returns to IDLE, and the next transaction completes normally.
- Across all scenarios, rf_wr_en & rf_rd_en is never 1, and at most one of a_gnt, b_gnt is high in any cycle.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter/sequencer for a single-port 8 x 16-bit register file.
// Optional macro REGARB_FIXED_PRIO_EN: ties always go to A instead of round-robin.
module regfile_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [2:0]  a_addr,
    input  logic [15:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [2:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,
    output logic        busy,
    output logic        rf_wr_en,
    output logic        rf_rd_en,
    output logic [2:0]  rf_addr,
    output logic [15:0] rf_wr_data,
    input  logic [15:0] rf_rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2
    } state_t;

    state_t      state_r;
    logic        owner_r;        // 0 = A, 1 = B
`ifndef REGARB_FIXED_PRIO_EN
    logic        last_winner_r;  // 0 = A, 1 = B
`endif

    logic        grant_a_s;
    logic        grant_b_s;
    logic        sel_we_s;
    logic [2:0]  sel_addr_s;
    logic [15:0] sel_wdata_s;

    // Pick the winner among the live requests for this IDLE cycle.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (a_req && b_req) begin
`ifdef REGARB_FIXED_PRIO_EN
            grant_a_s = 1'b1;
`else
            if (last_winner_r) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
`endif
        end else if (a_req) begin
            grant_a_s = 1'b1;
        end else if (b_req) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Route the winning requester's command toward the register-file port.
    always_comb begin
        if (grant_b_s) begin
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r       <= IDLE;
            owner_r       <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
            last_winner_r <= 1'b1;
`endif
            a_gnt         <= 1'b0;
            b_gnt         <= 1'b0;
            a_rvalid      <= 1'b0;
            b_rvalid      <= 1'b0;
            a_rdata       <= 16'h0000;
            b_rdata       <= 16'h0000;
            busy          <= 1'b0;
            rf_wr_en      <= 1'b0;
            rf_rd_en      <= 1'b0;
            rf_addr       <= 3'd0;
            rf_wr_data    <= 16'h0000;
        end else begin
            // Pulses default low; only the branch below may raise one.
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            rf_wr_en <= 1'b0;
            rf_rd_en <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_a_s || grant_b_s) begin
                        a_gnt         <= grant_a_s;
                        b_gnt         <= grant_b_s;
                        owner_r       <= grant_b_s;
`ifndef REGARB_FIXED_PRIO_EN
                        last_winner_r <= grant_b_s;
`endif
                        rf_addr       <= sel_addr_s;
                        rf_wr_data    <= sel_wdata_s;
                        rf_wr_en      <= sel_we_s;
                        rf_rd_en      <= ~sel_we_s;
                        busy          <= 1'b1;
                        state_r       <= ISSUE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    // The strobe that was raised on entry tells us the command type.
                    if (rf_wr_en) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy    <= 1'b1;
                        state_r <= CAPT;
                    end
                end
                CAPT: begin
                    if (owner_r) begin
                        b_rdata  <= rf_rd_data;
                        b_rvalid <= 1'b1;
                    end else begin
                        a_rdata  <= rf_rd_data;
                        a_rvalid <= 1'b1;
                    end
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register-file model.
module tb_regfile_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [2:0]  a_addr = 3'd0, b_addr = 3'd0;
    logic [15:0] a_wdata = 16'h0, b_wdata = 16'h0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, busy, rf_wr_en, rf_rd_en;
    logic [15:0] a_rdata, b_rdata, rf_wr_data;
    logic [2:0]  rf_addr;
    logic [15:0] rf_rd_data = 16'h0;
    logic [15:0] mem [8] = '{default: 16'h0};
    int          checks = 0;
    int          failures = 0;
    logic        exp_b;

    regfile_arbiter dut (
        .CLK(CLK), .RST(RST),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .busy(busy), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
        .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data)
    );

    always #5 CLK = ~CLK;

    // Register file model: synchronous write, registered read data.
    always @(posedge CLK) begin
        if (rf_wr_en) mem[rf_addr] <= rf_wr_data;
        if (rf_rd_en) rf_rd_data <= mem[rf_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    // Exclusivity of strobes and grants in every cycle.
    always @(negedge CLK) begin
        check_eq("strobe_excl", {31'd0, rf_wr_en & rf_rd_en}, 32'd0);
        check_eq("gnt_excl", {31'd0, a_gnt & b_gnt}, 32'd0);
    end

    initial begin
        // Reset held with a pending A write: nothing may be granted.
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd3; a_wdata = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("rst_gnt", {31'd0, a_gnt}, 32'd0);
            check_eq("rst_busy", {31'd0, busy}, 32'd0);
            check_eq("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
            check_eq("rst_rdata", {16'd0, a_rdata}, 32'd0);
            check_eq("rst_rf_addr", {29'd0, rf_addr}, 32'd0);
        end
        RST = 1'b0;
        cyc();
        check_eq("post_rst_gnt", {31'd0, a_gnt}, 32'd1);
        check_eq("post_rst_wr_en", {31'd0, rf_wr_en}, 32'd1);
        check_eq("post_rst_addr", {29'd0, rf_addr}, 32'd3);
        a_req = 1'b0;
        cyc();
        check_eq("post_rst_idle", {31'd0, busy}, 32'd0);

        // A writes 0xBEEF to address 5.
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd5; a_wdata = 16'hBEEF;
        cyc();
        check_eq("wr_gnt", {31'd0, a_gnt}, 32'd1);
        check_eq("wr_strobe", {30'd0, rf_wr_en, rf_rd_en}, 32'd2);
        check_eq("wr_addr", {29'd0, rf_addr}, 32'd5);
        check_eq("wr_data", {16'd0, rf_wr_data}, 32'h0000BEEF);
        a_req = 1'b0;
        cyc();
        check_eq("wr_done", {29'd0, busy, rf_wr_en, a_gnt}, 32'd0);

        // A reads address 5: rvalid three cycles after the sample.
        a_req = 1'b1; a_we = 1'b0;
        cyc();
        check_eq("rd_gnt", {31'd0, a_gnt}, 32'd1);
        check_eq("rd_strobe", {30'd0, rf_wr_en, rf_rd_en}, 32'd1);
        a_req = 1'b0;
        cyc();
        check_eq("rd_capt", {30'd0, busy, a_rvalid}, 32'd2);
        cyc();
        check_eq("rd_rvalid", {31'd0, a_rvalid}, 32'd1);
        check_eq("rd_rdata", {16'd0, a_rdata}, 32'h0000BEEF);
        check_eq("rd_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        check_eq("rd_idle", {31'd0, busy}, 32'd0);
        cyc();
        check_eq("rd_pulse", {31'd0, a_rvalid}, 32'd0);

        // B writes 0x7777 to address 7, making B the last winner.
        b_req = 1'b1; b_we = 1'b1; b_addr = 3'd7; b_wdata = 16'h7777;
        cyc();
        check_eq("bwr_gnt", {30'd0, a_gnt, b_gnt}, 32'd1);
        check_eq("bwr_addr", {29'd0, rf_addr}, 32'd7);
        b_req = 1'b0;
        cyc();

        // Both hold write requests: A, B, A, B (A only with fixed priority).
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd1; a_wdata = 16'h1111;
        b_req = 1'b1; b_we = 1'b1; b_addr = 3'd2; b_wdata = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            cyc();
`ifdef REGARB_FIXED_PRIO_EN
            exp_b = 1'b0;
`else
            exp_b = (i % 2) == 1;
`endif
            check_eq("tie_gnt", {30'd0, a_gnt, b_gnt}, {30'd0, ~exp_b, exp_b});
            check_eq("tie_wdata", {16'd0, rf_wr_data}, exp_b ? 32'h00002222 : 32'h00001111);
            if (i == 3) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            cyc();
            check_eq("tie_gap", {30'd0, a_gnt, b_gnt}, 32'd0);
        end

        // B reads address 7; A's request during CAPT waits for IDLE.
        b_req = 1'b1; b_we = 1'b0; b_addr = 3'd7;
        cyc();
        check_eq("brd_gnt", {30'd0, a_gnt, b_gnt}, 32'd1);
        b_req = 1'b0;
        cyc();
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd5;
        cyc();
        check_eq("brd_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd1);
        check_eq("brd_rdata", {16'd0, b_rdata}, 32'h00007777);
        check_eq("brd_a_ignored", {31'd0, a_gnt}, 32'd0);
        cyc();
        check_eq("ard_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
        a_req = 1'b0;
        cyc();
        cyc();
        check_eq("ard_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd2);
        check_eq("ard_rdata", {16'd0, a_rdata}, 32'h0000BEEF);
        check_eq("brd_hold", {16'd0, b_rdata}, 32'h00007777);

        // Reset pulse during CAPT of an A read of address 1.
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd1;
        cyc();
        check_eq("rrd_gnt", {31'd0, a_gnt}, 32'd1);
        a_req = 1'b0;
        cyc();
        check_eq("rrd_capt", {31'd0, busy}, 32'd1);
        RST = 1'b1;
        #1;
        check_eq("rrd_async_busy", {31'd0, busy}, 32'd0);
        cyc();
        check_eq("rrd_no_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        check_eq("rrd_rdata_clr", {16'd0, a_rdata}, 32'd0);
        RST = 1'b0;
        cyc();
        check_eq("rrd_no_rvalid2", {31'd0, a_rvalid}, 32'd0);
        check_eq("rrd_idle", {31'd0, busy}, 32'd0);

        // Normal read of address 7 after recovery.
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd7;
        cyc();
        check_eq("rec_gnt", {31'd0, a_gnt}, 32'd1);
        a_req = 1'b0;
        cyc();
        cyc();
        check_eq("rec_rvalid", {31'd0, a_rvalid}, 32'd1);
        check_eq("rec_rdata", {16'd0, a_rdata}, 32'h00007777);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
